// File: rtl/branch_resolve_if.sv
// Branch resolve bus between the execute stage and the branch resolve unit.
//
// Purpose: bundles the decoder/ALU controls going into the branch resolve unit
// with the redirect, flush, flag and statistics outputs coming back from it.
//
// Signals:
//   Valid, Stall            execute-stage qualifiers
//   BranchSelect[1:0]       00 none, 01 always, 10 equal (Z), 11 less-than (N^V)
//   SetFlags                instruction writes NZCV
//   ALUFlags[3:0]           {N,Z,C,V} from the ALU
//   BranchTarget[ADDR_W]    resolved branch target
//   PCSrc, NextPC           one-cycle redirect strobe and address to fetch
//   Flush                   squash IF/ID/EX
//   Flags[3:0]              architectural NZCV register
//   TakenCount[CNT_W]       taken-branch counter
//
// Modports: master = execute stage side (drives controls), slave = the unit.
interface branch_resolve_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              Valid;
  logic              Stall;
  logic [1:0]        BranchSelect;
  logic              SetFlags;
  logic [3:0]        ALUFlags;
  logic [ADDR_W-1:0] BranchTarget;
  logic              PCSrc;
  logic [ADDR_W-1:0] NextPC;
  logic              Flush;
  logic [3:0]        Flags;
  logic [CNT_W-1:0]  TakenCount;

  modport master (
    output Valid, Stall, BranchSelect, SetFlags, ALUFlags, BranchTarget,
    input  PCSrc, NextPC, Flush, Flags, TakenCount
  );

  modport slave (
    input  Valid, Stall, BranchSelect, SetFlags, ALUFlags, BranchTarget,
    output PCSrc, NextPC, Flush, Flags, TakenCount
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit (execute stage).
//
// Purpose: holds the architectural NZCV register, evaluates the branch
// condition using same-cycle forwarded ALU flags, and on a taken branch emits a
// one-cycle PC redirect followed by a FLUSH_CYCLES-long squash window. Also
// counts taken branches.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   branch_resolve_if.slave (controls in; PCSrc/NextPC/Flush/Flags/TakenCount out)
//
// Parameters:
//   ADDR_W        PC / target width
//   FLUSH_CYCLES  cycles Flush stays high after a taken branch (0..7)
//   CNT_W         taken-branch counter width
module branch_resolve_unit #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst,
  branch_resolve_if.slave  bus
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic              pcsrc_q;
  logic [ADDR_W-1:0] next_pc_q;
  logic              flush_q;
  logic [2:0]        flush_cnt;
  logic [2:0]        flush_cnt_next;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  taken_cnt;

  logic eff_n;
  logic eff_z;
  logic eff_v;
  logic cond;
  logic active;
  logic taken;

  // A compare-and-branch must see its own fresh ALU flags, so the flags used
  // for the condition come straight from the ALU whenever the instruction
  // also writes NZCV. Carry never participates in branching.
  assign eff_n = bus.SetFlags ? bus.ALUFlags[3] : flags_q[3];
  assign eff_z = bus.SetFlags ? bus.ALUFlags[2] : flags_q[2];
  assign eff_v = bus.SetFlags ? bus.ALUFlags[0] : flags_q[0];

  always_comb begin
    cond = 1'b0;
    unique case (bus.BranchSelect)
      2'b00: cond = 1'b0;
      2'b01: cond = 1'b1;
      2'b10: cond = eff_z;
      2'b11: cond = eff_n ^ eff_v;
      default: cond = 1'b0;
    endcase
  end

  // Anything arriving during the flush window is on the wrong path.
  assign active = bus.Valid & ~bus.Stall & ~flush_q;
  assign taken  = active & cond;

  // A taken branch reloads the flush window; otherwise it drains by one.
  always_comb begin
    flush_cnt_next = flush_cnt;
    if (taken) begin
      flush_cnt_next = FLUSH_LOAD;
    end else if (flush_cnt != 3'd0) begin
      flush_cnt_next = flush_cnt - 3'd1;
    end
  end

  // Stall freezes every register, including the redirect pulse, so the fetch
  // stage still sees PCSrc once the pipeline resumes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcsrc_q   <= 1'b0;
      next_pc_q <= '0;
      flush_q   <= 1'b0;
      flush_cnt <= 3'd0;
      flags_q   <= 4'b0000;
      taken_cnt <= '0;
    end else if (!bus.Stall) begin
      pcsrc_q   <= taken;
      flush_cnt <= flush_cnt_next;
      flush_q   <= (flush_cnt_next != 3'd0);
      if (taken) begin
        next_pc_q <= bus.BranchTarget;
        taken_cnt <= taken_cnt + CNT_W'(1);
      end
      if (active && bus.SetFlags) begin
        flags_q <= bus.ALUFlags;
      end
    end
  end

  assign bus.PCSrc      = pcsrc_q;
  assign bus.NextPC     = next_pc_q;
  assign bus.Flush      = flush_q;
  assign bus.Flags      = flags_q;
  assign bus.TakenCount = taken_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit.
//
// Purpose: table-driven directed vectors against a unit built with CNT_W=2 so
// the taken counter wraps quickly, plus a hand-written sequence against a
// second unit built with FLUSH_CYCLES=0.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;

  int checks;
  int failures;

  branch_resolve_if #(.ADDR_W(32), .CNT_W(2))  bus ();
  branch_resolve_if #(.ADDR_W(32), .CNT_W(16)) bus0 ();

  branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(0), .CNT_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        stall;
    logic [1:0]  sel;
    logic        set;
    logic [3:0]  alu;
    logic [31:0] tgt;
    logic        e_pcsrc;
    logic [31:0] e_npc;
    logic        e_flush;
    logic [3:0]  e_flags;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [1:0] sel, input logic set,
                              input logic [3:0] alu, input logic [31:0] tgt,
                              input logic ep, input logic [31:0] enpc,
                              input logic ef, input logic [3:0] efl,
                              input logic [1:0] ec);
    vec_t x;
    x.rst = r; x.valid = v; x.stall = s; x.sel = sel; x.set = set;
    x.alu = alu; x.tgt = tgt;
    x.e_pcsrc = ep; x.e_npc = enpc; x.e_flush = ef; x.e_flags = efl;
    x.e_cnt = ec;
    return x;
  endfunction

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL row %0d %s: got %h expected %h", row, name, act, exp);
    end
  endtask

  // Drive one vector into the main unit, then let one rising edge pass and
  // sample 1 ns later.
  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    bus.Valid          = v.valid;
    bus.Stall          = v.stall;
    bus.BranchSelect   = v.sel;
    bus.SetFlags       = v.set;
    bus.ALUFlags       = v.alu;
    bus.BranchTarget   = v.tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic step0(input logic v, input logic [1:0] sel, input logic set,
                       input logic [3:0] alu, input logic [31:0] tgt);
    bus0.Valid        = v;
    bus0.BranchSelect = sel;
    bus0.SetFlags     = set;
    bus0.ALUFlags     = alu;
    bus0.BranchTarget = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    rst = 1'b1;
    bus.Valid = 1'b0; bus.Stall = 1'b0; bus.BranchSelect = 2'b00;
    bus.SetFlags = 1'b0; bus.ALUFlags = 4'h0; bus.BranchTarget = 32'h0;
    bus0.Valid = 1'b0; bus0.Stall = 1'b0; bus0.BranchSelect = 2'b00;
    bus0.SetFlags = 1'b0; bus0.ALUFlags = 4'h0; bus0.BranchTarget = 32'h0;

    // Reset with arbitrary inputs, then idle.
    vecs.push_back(mk(1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 4'($urandom), $urandom, 0, 32'h0, 0, 4'h0, 2'd0));
    vecs.push_back(mk(1, 1, 0, 2'b01, 1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 0, 4'h0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 2'b01, 1, 4'hF, 32'h44, 0, 32'h0, 0, 4'h0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 2'b10, 1, 4'h4, 32'h48, 0, 32'h0, 0, 4'h0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,  0, 32'h0, 0, 4'h0, 2'd0));
    // Unconditional branch: PCSrc one cycle, Flush two cycles.
    vecs.push_back(mk(0, 1, 0, 2'b01, 0, 4'h0, 32'h40, 1, 32'h40, 1, 4'h0, 2'd1));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,  0, 32'h40, 1, 4'h0, 2'd1));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,  0, 32'h40, 0, 4'h0, 2'd1));
    // Same-cycle forwarding: equal branch on fresh Z.
    vecs.push_back(mk(0, 1, 0, 2'b10, 1, 4'h4, 32'h80, 1, 32'h80, 1, 4'h4, 2'd2));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,  0, 32'h80, 1, 4'h4, 2'd2));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,  0, 32'h80, 0, 4'h4, 2'd2));
    // Clear flags, then equal branch on stored flags: not taken.
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 4'h0, 32'h0,  0, 32'h80, 0, 4'h0, 2'd2));
    vecs.push_back(mk(0, 1, 0, 2'b10, 0, 4'h4, 32'hC0, 0, 32'h80, 0, 4'h0, 2'd2));
    // Stored N=1,V=0 -> less-than taken.
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 4'h8, 32'h0,   0, 32'h80,  0, 4'h8, 2'd2));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 4'h0, 32'h100, 1, 32'h100, 1, 4'h8, 2'd3));
    // Squashed branch with flag write in the flush window.
    vecs.push_back(mk(0, 1, 0, 2'b01, 1, 4'hF, 32'h200, 0, 32'h100, 1, 4'h8, 2'd3));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,   0, 32'h100, 0, 4'h8, 2'd3));
    // Stored N=1,V=1 -> less-than not taken.
    vecs.push_back(mk(0, 1, 0, 2'b00, 1, 4'h9, 32'h0,   0, 32'h100, 0, 4'h9, 2'd3));
    vecs.push_back(mk(0, 1, 0, 2'b11, 0, 4'h0, 32'h140, 0, 32'h100, 0, 4'h9, 2'd3));
    // Carry alone must not satisfy any condition.
    vecs.push_back(mk(0, 1, 0, 2'b10, 1, 4'h2, 32'h180, 0, 32'h100, 0, 4'h2, 2'd3));
    // Fourth taken branch wraps the 2-bit counter.
    vecs.push_back(mk(0, 1, 0, 2'b01, 0, 4'h0, 32'h1C0, 1, 32'h1C0, 1, 4'h2, 2'd0));
    // Stall in the PCSrc cycle for 3 cycles: everything holds.
    vecs.push_back(mk(0, 1, 1, 2'b01, 1, 4'hF, 32'h240, 1, 32'h1C0, 1, 4'h2, 2'd0));
    vecs.push_back(mk(0, 1, 1, 2'b01, 1, 4'hF, 32'h240, 1, 32'h1C0, 1, 4'h2, 2'd0));
    vecs.push_back(mk(0, 1, 1, 2'b01, 1, 4'hF, 32'h240, 1, 32'h1C0, 1, 4'h2, 2'd0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,   0, 32'h1C0, 1, 4'h2, 2'd0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,   0, 32'h1C0, 0, 4'h2, 2'd0));
    // Stall with a valid branch outside the flush window: ignored.
    vecs.push_back(mk(0, 1, 1, 2'b01, 1, 4'h8, 32'h260, 0, 32'h1C0, 0, 4'h2, 2'd0));
    // Forwarded less-than with N=0,V=1.
    vecs.push_back(mk(0, 1, 0, 2'b11, 1, 4'h1, 32'h280, 1, 32'h280, 1, 4'h1, 2'd1));
    // Reset mid-redirect/mid-flush clears everything at once.
    vecs.push_back(mk(1, 1, 0, 2'b01, 1, 4'hF, 32'h2C0, 0, 32'h0, 0, 4'h0, 2'd0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 4'h0, 32'h0,   0, 32'h0, 0, 4'h0, 2'd0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput("PCSrc",      i, 32'(bus.PCSrc),      32'(vecs[i].e_pcsrc));
      checkOutput("NextPC",     i, bus.NextPC,          vecs[i].e_npc);
      checkOutput("Flush",      i, 32'(bus.Flush),      32'(vecs[i].e_flush));
      checkOutput("Flags",      i, 32'(bus.Flags),      32'(vecs[i].e_flags));
      checkOutput("TakenCount", i, 32'(bus.TakenCount), 32'(vecs[i].e_cnt));
    end

    // FLUSH_CYCLES=0 unit: idle after reset, then back-to-back taken
    // branches each pulse PCSrc while Flush never rises.
    checkOutput("z_reset_PCSrc", 100, 32'(bus0.PCSrc), 32'd0);
    checkOutput("z_reset_Count", 100, 32'(bus0.TakenCount), 32'd0);
    step0(1, 2'b01, 0, 4'h0, 32'h300);
    checkOutput("z_PCSrc", 101, 32'(bus0.PCSrc), 32'd1);
    checkOutput("z_NextPC", 101, bus0.NextPC, 32'h300);
    checkOutput("z_Flush", 101, 32'(bus0.Flush), 32'd0);
    checkOutput("z_Count", 101, 32'(bus0.TakenCount), 32'd1);
    step0(1, 2'b10, 1, 4'h4, 32'h340);
    checkOutput("z_PCSrc", 102, 32'(bus0.PCSrc), 32'd1);
    checkOutput("z_NextPC", 102, bus0.NextPC, 32'h340);
    checkOutput("z_Flush", 102, 32'(bus0.Flush), 32'd0);
    checkOutput("z_Flags", 102, 32'(bus0.Flags), 32'h4);
    checkOutput("z_Count", 102, 32'(bus0.TakenCount), 32'd2);
    step0(0, 2'b00, 0, 4'h0, 32'h0);
    checkOutput("z_PCSrc", 103, 32'(bus0.PCSrc), 32'd0);
    checkOutput("z_NextPC", 103, bus0.NextPC, 32'h340);
    checkOutput("z_Flush", 103, 32'(bus0.Flush), 32'd0);
    checkOutput("z_Count", 103, 32'(bus0.TakenCount), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
